imem_loader: RTL



---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a length-prefixed little-endian byte stream into
// 32-bit instruction words, writes them from address 0, then releases the core.
module imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [7:0]        hdr0;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       byte_buf;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              xfer;
    logic              hdr_ok;
    logic              tmo_hit;
    logic [16:0]       hdr_n;

    assign rx_ready_o = (state == S_HDR0) || (state == S_HDR1) || (state == S_LOAD);
    assign busy_o     = rx_ready_o || (state == S_FLUSH);
    assign xfer       = rx_valid_i && rx_ready_o;
    assign hdr_n      = {1'b0, rx_data_i, hdr0};
    assign hdr_ok     = (hdr_n != 17'd0) && (hdr_n <= 17'(DEPTH));
    // The idle counter only ever reaches TIMEOUT_CYC-1; the next idle cycle trips it.
    assign tmo_hit    = (TIMEOUT_CYC != 0) && !xfer && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            hdr0           <= '0;
            last_idx       <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            byte_buf       <= '0;
            tmo_cnt        <= '0;
            imem_we_o      <= 1'b0;
            imem_addr_o    <= '0;
            imem_wdata_o   <= '0;
            core_rst_o     <= 1'b1;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            words_loaded_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            if (imem_we_o) begin
                words_loaded_o <= words_loaded_o + 1'b1;
            end
            if (rx_ready_o) begin
                tmo_cnt <= xfer ? '0 : tmo_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state    <= S_HDR0;
                        tmo_cnt  <= '0;
                        byte_idx <= '0;
                        word_idx <= '0;
                    end
                end
                S_HDR0: begin
                    if (xfer) begin
                        hdr0  <= rx_data_i;
                        state <= S_HDR1;
                    end else if (tmo_hit) begin
                        state <= S_ERROR;
                        err_o <= 1'b1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        last_idx <= ADDR_W'(hdr_n - 17'd1);
                        if (hdr_ok) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_ERROR;
                            err_o <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state <= S_ERROR;
                        err_o <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd0) begin
                            byte_buf[7:0] <= rx_data_i;
                        end else if (byte_idx == 2'd1) begin
                            byte_buf[15:8] <= rx_data_i;
                        end else if (byte_idx == 2'd2) begin
                            byte_buf[23:16] <= rx_data_i;
                        end else begin
                            // Word complete: strobe it next cycle while the next word streams in.
                            imem_we_o    <= 1'b1;
                            imem_addr_o  <= word_idx;
                            imem_wdata_o <= {rx_data_i, byte_buf};
                            if (word_idx == last_idx) begin
                                state <= S_FLUSH;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        state <= S_ERROR;
                        err_o <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    state      <= S_DONE;
                    done_o     <= 1'b1;
                    core_rst_o <= 1'b0;
                end
                S_DONE, S_ERROR: begin
                    if (start_i) begin
                        state          <= S_HDR0;
                        done_o         <= 1'b0;
                        err_o          <= 1'b0;
                        core_rst_o     <= 1'b1;
                        words_loaded_o <= '0;
                        word_idx       <= '0;
                        byte_idx       <= '0;
                        tmo_cnt        <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
